// File: rtl/adder16_result_checker.sv
// Consumer-side checker for the registered adder: rebuilds a+b, delays it to line up
// with the adder output, compares, and keeps pass/fail statistics plus the first failure.
module adder16_result_checker #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_dut_sum,
  input  logic             i_clear,
  output logic             o_chk_valid,
  output logic             o_mismatch,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_chk_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic [WIDTH-1:0] o_first_a,
  output logic [WIDTH-1:0] o_first_b,
  output logic [WIDTH-1:0] o_first_exp,
  output logic [WIDTH-1:0] o_first_got,
  output logic             o_halted
);

  // state  | meaning
  // RUN    | comparisons enabled
  // HALTED | stopped at first mismatch; pipeline output is discarded until clear
  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_pv [LATENCY];
  logic [WIDTH-1:0] r_pa [LATENCY];
  logic [WIDTH-1:0] r_pb [LATENCY];
  logic [WIDTH-1:0] r_pe [LATENCY];

  logic             r_chk_valid;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_chk_count;
  logic [CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0] r_first_a;
  logic [WIDTH-1:0] r_first_b;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_got;

  logic [WIDTH-1:0] w_exp_in;
  logic             w_pipe_vld;
  logic [WIDTH-1:0] w_pipe_a;
  logic [WIDTH-1:0] w_pipe_b;
  logic [WIDTH-1:0] w_pipe_exp;
  logic             w_cmp_en;
  logic             w_miss;
  logic             w_chk_sat;
  logic             w_err_sat;

  // Carry-out is dropped, exactly as the adder does.
  assign w_exp_in   = i_a + i_b;

  assign w_pipe_vld = r_pv[LATENCY-1];
  assign w_pipe_a   = r_pa[LATENCY-1];
  assign w_pipe_b   = r_pb[LATENCY-1];
  assign w_pipe_exp = r_pe[LATENCY-1];

  assign w_chk_sat  = &r_chk_count;
  assign w_err_sat  = &r_err_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pb[i] <= '0;
        r_pe[i] <= '0;
      end
    end else begin
      r_pv[0] <= i_in_valid;
      r_pa[0] <= i_a;
      r_pb[0] <= i_b;
      r_pe[0] <= w_exp_in;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear beats a comparison landing on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cmp_en    = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_cmp_en = w_pipe_vld && !i_clear;
        w_miss   = w_cmp_en && (i_dut_sum != w_pipe_exp);
        if (w_miss && STOP_ON_ERR) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
    endcase
    if (i_clear) begin
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_chk_valid <= 1'b0;
      r_mismatch  <= 1'b0;
      r_chk_count <= '0;
      r_err_count <= '0;
    end else begin
      r_chk_valid <= w_cmp_en;
      r_mismatch  <= w_miss;
      if (w_cmp_en && !w_chk_sat) begin
        r_chk_count <= r_chk_count + CNT_ONE;
      end
      if (w_miss && !w_err_sat) begin
        r_err_count <= r_err_count + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_err_sticky <= 1'b0;
      r_first_a    <= '0;
      r_first_b    <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
    end else if (w_miss && !r_err_sticky) begin
      r_err_sticky <= 1'b1;
      r_first_a    <= w_pipe_a;
      r_first_b    <= w_pipe_b;
      r_first_exp  <= w_pipe_exp;
      r_first_got  <= i_dut_sum;
    end
  end

  assign o_chk_valid  = r_chk_valid;
  assign o_mismatch   = r_mismatch;
  assign o_err_sticky = r_err_sticky;
  assign o_chk_count  = r_chk_count;
  assign o_err_count  = r_err_count;
  assign o_first_a    = r_first_a;
  assign o_first_b    = r_first_b;
  assign o_first_exp  = r_first_exp;
  assign o_first_got  = r_first_got;
  assign o_halted     = (r_state == S_HALTED);

endmodule

// File: doc/adder16_result_checker.md
Name: adder16_result_checker

Overview:
- Synthesizable response checker on the consumer side of the 16-bit registered adder interface.
- Captures each operand pair presented to the adder and rebuilds the expected sum internally.
- Aligns the expected sum to the adder's output latency, compares it with the returned sum, and keeps pass/fail statistics plus the first failing transaction.
- Sits beside the adder in timing-characterization builds, so self-checking stays on-chip in both silicon and simulation.

Parameters:
- WIDTH, 16, operand and sum width.
- LATENCY, 1, cycles from operands sampled to sum valid at the adder output; legal range 1..8.
- CNT_W, 16, width of the check and error counters.
- STOP_ON_ERR, 0, when 1, checking halts at the first mismatch.

Ports:
- clk  in  1  rising-edge clock shared with the adder.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  a/b carry a transaction this cycle.
- a  in  WIDTH  operand A as driven to the adder.
- b  in  WIDTH  operand B as driven to the adder.
- dut_sum  in  WIDTH  sum returned by the adder.
- clear  in  1  synchronous clear of statistics and the HALTED state.
- chk_valid  out  1  one-cycle pulse: a comparison was made this cycle.
- mismatch  out  1  one-cycle pulse with chk_valid when the comparison failed.
- err_sticky  out  1  set on the first mismatch, held until clear or reset.
- chk_count  out  CNT_W  number of comparisons made (saturating).
- err_count  out  CNT_W  number of mismatches (saturating).
- first_a, first_b, first_exp, first_got  out  WIDTH each  capture of the first failing transaction.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0 and all pipeline valid bits clear.
  - State goes to RUN.
  - Reset has priority over clear and in_valid, including mid-pipeline; in-flight transactions are dropped and never compared.
- Expected value:
  - exp = (a + b) mod 2^WIDTH. The carry-out is discarded, matching the adder.
  - Example: FFFF+0001 gives expected 0000.
- Alignment pipeline:
  - LATENCY-deep shift register of {valid, a, b, exp}.
  - A transaction sampled at edge N is compared against dut_sum as sampled at edge N+LATENCY.
  - Registered outputs therefore update at edge N+LATENCY; chk_valid is high during the following cycle.
  - Back-to-back in_valid at full throughput is supported. Bubbles (in_valid=0) produce no chk_valid.
- Comparison when the pipeline output is valid and the state is RUN:
  - chk_valid=1 and chk_count increments.
  - If dut_sum != exp: mismatch=1 and err_count increments.
  - If err_sticky was 0, first_a/first_b/first_exp/first_got are loaded and err_sticky is set.
- Counters saturate at 2^CNT_W-1 and never wrap.
- State machine, two states:
  - RUN: comparisons enabled. On a mismatch with STOP_ON_ERR=1, go to HALTED on the same edge that records the error.
  - HALTED: no comparisons. chk_valid/mismatch stay 0 and counters and captures are frozen. The pipeline keeps shifting, and its outputs are discarded.
  - clear=1 in either state: return to RUN, zero chk_count, err_count, err_sticky and captures, and drop all pipeline valid bits.
- Simultaneous clear and pipeline-valid on the same edge: clear wins and the comparison is not counted.
- Simultaneous clear and in_valid: the new transaction is also dropped.
- With STOP_ON_ERR=0, HALTED is unreachable and halted stays 0.

Test Plan:
- Reset then pairs 10+5, 100+200, FFFF+1 with the adder model correct, LATENCY=1 -> three chk_valid pulses at edges N+1, chk_count=3, err_count=0, err_sticky=0.
- Wrap case FFFF+0001 with dut_sum forced to 0x10000-truncated 0000 -> pass. With dut_sum forced to 0001 -> mismatch pulse, first_a=FFFF, first_b=0001, first_exp=0000, first_got=0001.
- Two injected errors (second on 64+64 returning 0081), STOP_ON_ERR=0 -> err_count=2, captures still hold the first error, err_sticky=1.
- STOP_ON_ERR=1, error on the 2nd of 5 transactions -> halted=1 and chk_count=2 frozen. Then pulse clear -> all zero, RUN state; the next pair 3+4 is counted (chk_count=1).
- LATENCY=3, continuous in_valid for 8 cycles with one bubble in the middle -> exactly 7 chk_valid pulses, each 3 edges after its input.
- rst_n low for one cycle with 2 transactions in flight -> no chk_valid afterwards for them, all outputs 0; CNT_W=4 with 20 passing checks -> chk_count holds at 15.
